// File: rtl/sensor_conditioner.sv
// -----------------------------------------------------------------------------
// sensor_conditioner
//
// Conditions the raw vehicle-loop contact for a trafficlight controller. The
// raw contact is synchronised, debounced and turned into a latched side-road
// request. The request is dropped as soon as the side road is shown green.
//
// Optional feature (macro SENSOR_COUNT_EN):
//   defined   -> an 8-bit saturating count of accepted arrivals is built.
//   undefined -> arrivals is tied to 0 and no counter flops exist.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive stable synchronised cycles needed to accept
//                    a level change (legal range 2..255, default 16)
//   SIDE_GREEN       light code meaning "side road green" (default 2'b10)
//
// Ports
//   clk         in   single clock, rising edge
//   rst_n       in   synchronous active-low reset
//   sensor_raw  in   asynchronous, bouncy loop contact
//   light       in   [1:0] current light code from the controller
//   sensor_out  out  latched vehicle request (registered)
//   sensor_db   out  debounced presence level (registered)
//   arrivals    out  [7:0] accepted arrival count (registered or constant 0)
// -----------------------------------------------------------------------------
module sensor_conditioner #(
  parameter int         DEBOUNCE_CYCLES = 16,
  parameter logic [1:0] SIDE_GREEN      = 2'b10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sensor_raw,
  input  logic [1:0] light,
  output logic       sensor_out,
  output logic       sensor_db,
  output logic [7:0] arrivals
);

  // Counter value on which the next differing sample completes the debounce.
  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic       s1_q;
  logic       s2_q;
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic       db_q;
  logic       db_d;
  logic       req_q;
  logic       req_d;
  logic       arrival_s;
  logic       green_s;

  // Two-flop synchroniser for the asynchronous loop contact.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= sensor_raw;
      s2_q <= s1_q;
    end
  end

  // Debounce next state: count consecutive samples that disagree with the
  // accepted level; any agreeing sample throws away the progress so far.
  always_comb begin
    cnt_d = 8'd0;
    db_d  = db_q;
    if (s2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d  = s2_q;
        cnt_d = 8'd0;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end else begin
      cnt_d = 8'd0;
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
      db_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      db_q  <= db_d;
    end
  end

  // Arrival is the edge on which the debounced level is about to rise.
  always_comb begin
    arrival_s = db_d & ~db_q;
    green_s   = (light == SIDE_GREEN);
  end

  // Request latch: green clears with priority, since the waiting vehicle is
  // served by the green already showing.
  always_comb begin
    req_d = req_q;
    if (green_s) begin
      req_d = 1'b0;
    end else if (arrival_s) begin
      req_d = 1'b1;
    end else begin
      req_d = req_q;
    end
  end

  // Request register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_q <= 1'b0;
    end else begin
      req_q <= req_d;
    end
  end

  assign sensor_out = req_q;
  assign sensor_db  = db_q;

`ifdef SENSOR_COUNT_EN
  logic [7:0] arr_q;
  logic [7:0] arr_d;

  // Saturating arrival count: holds at 255 rather than wrapping.
  always_comb begin
    arr_d = arr_q;
    if (arrival_s && (arr_q != 8'hFF)) begin
      arr_d = arr_q + 8'd1;
    end else begin
      arr_d = arr_q;
    end
  end

  // Arrival count register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      arr_q <= 8'd0;
    end else begin
      arr_q <= arr_d;
    end
  end

  assign arrivals = arr_q;
`else
  assign arrivals = 8'h00;
`endif

endmodule

// File: doc/sensor_conditioner.md
SENSOR_CONDITIONER -- requirements
Module: sensor_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 16, legal range 2..255, giving the number of consecutive stable cycles needed to accept a sensor level change.
REQ-002 The block SHALL have parameter SIDE_GREEN, default 2'b10, giving the light code that means the side road is green.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 sensor_raw  input  1  asynchronous, bouncy vehicle-loop contact (from ui_in[0]).
REQ-006 light  input  2  current light code fed back from the downstream trafficlight controller.
REQ-007 sensor_out  output  1  latched vehicle request; drives the controller's sensor input.
REQ-008 sensor_db  output  1  debounced presence level.
REQ-009 arrivals  output  8  count of accepted vehicle arrivals.

Function
REQ-010 sensor_raw SHALL pass through a 2-flop synchronizer (s1, then s2) before any other use.
REQ-011 An 8-bit stability counter SHALL increment on each edge where s2 differs from sensor_db, and SHALL clear to 0 on any edge where s2 equals sensor_db.
REQ-012 On an edge where s2 differs from sensor_db and the counter equals DEBOUNCE_CYCLES-1, sensor_db SHALL take the value of s2 and the counter SHALL clear.
REQ-013 Latency: a clean raw transition first sampled at edge E SHALL appear on sensor_db at edge E+DEBOUNCE_CYCLES+1 (edge E+17 at the default).
REQ-014 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL NOT change sensor_db; the glitch SHALL restart the counter.
REQ-015 An arrival event SHALL be the edge on which sensor_db goes 0->1; there SHALL be no event on the 1->0 transition.
REQ-016 sensor_out SHALL set to 1 on an arrival edge and hold until cleared.
REQ-017 sensor_out SHALL clear to 0 on any edge where light equals SIDE_GREEN.
REQ-018 On an edge with both an arrival and light==SIDE_GREEN, clear SHALL win and sensor_out SHALL be 0, because the vehicle is served by the current green.
REQ-019 A further arrival while sensor_out is already 1 SHALL leave sensor_out at 1.
REQ-020 arrivals SHALL increment by 1 on each arrival edge and SHALL saturate at 255; it SHALL never wrap.
REQ-021 All outputs SHALL be driven directly from registers, with no combinational path from input to output.

Reset
REQ-022 With rst_n low at a rising edge: s1, s2, counter, sensor_db, sensor_out and arrivals SHALL become 0.
REQ-023 Asserting reset mid-debounce SHALL discard all progress; after release, a high sensor_raw SHALL require the full REQ-013 latency again.
REQ-024 The first arrival SHALL be possible on the edge DEBOUNCE_CYCLES+1 edges after the first edge with rst_n high, if sensor_raw is high throughout.

Configuration
REQ-025 With macro SENSOR_COUNT_EN defined, the arrivals counter SHALL be built as specified in REQ-020.
REQ-026 Without SENSOR_COUNT_EN, arrivals SHALL be constant 0, no counter flops SHALL be built, and all other behaviour SHALL be unchanged.

Verification (DEBOUNCE_CYCLES=4 unless stated)
REQ-027 Reset, then raw held high from edge 1 -> sensor_db and sensor_out go 1 at edge 6; arrivals=1.
REQ-028 Raw high for 3 cycles, then low, repeated 10 times -> sensor_db, sensor_out and arrivals stay 0.
REQ-029 sensor_out=1, then light=2'b10 for 1 cycle -> sensor_out=0 on that edge; light codes 00, 01 and 11 leave it at 1.
REQ-030 Arrival edge coincides with light=2'b10 -> sensor_out=0, arrivals still increments.
REQ-031 300 clean arrivals with SENSOR_COUNT_EN -> arrivals=255; without the macro -> arrivals=0 throughout.
REQ-032 rst_n low for 1 cycle at counter=2 during a rising debounce -> after release, sensor_db rises exactly 5 edges later.
